// File: rtl/fifo_stream_drain_pkg.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_drain_pkg
// Brief    : Shared constants and types for the FIFO read-side stream drain.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package fifo_stream_drain_pkg;

    localparam int c_FIFO_WIDTH = 16;
    localparam int c_PKT_LEN    = 4;
    localparam int c_CNT_WIDTH  = 16;

    typedef logic [c_FIFO_WIDTH-1:0] fifo_data_t;

    // Beat counter width; a single-beat packet still needs a 1-bit register.
    function automatic int beat_width(input int pkt_len);
        return (pkt_len > 1) ? $clog2(pkt_len) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/fifo_stream_drain_if.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_drain_if
// Brief    : FIFO read port plus valid/ready stream bundle for the drain block.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface fifo_stream_drain_if #(
    parameter int FIFO_WIDTH = 16,
    parameter int CNT_WIDTH  = 16
);
    logic                  drain_en;
    logic                  fifo_empty;
    logic [FIFO_WIDTH-1:0] fifo_dout;
    logic                  fifo_rd_en;
    logic [FIFO_WIDTH-1:0] m_data;
    logic                  m_valid;
    logic                  m_ready;
    logic                  m_last;
    logic [CNT_WIDTH-1:0]  pkt_count;
    logic                  busy;

    // master: the drain block itself
    modport master (
        input  drain_en, fifo_empty, fifo_dout, m_ready,
        output fifo_rd_en, m_data, m_valid, m_last, pkt_count, busy
    );

    // slave: the FIFO and downstream sink around it
    modport slave (
        output drain_en, fifo_empty, fifo_dout, m_ready,
        input  fifo_rd_en, m_data, m_valid, m_last, pkt_count, busy
    );
endinterface

`default_nettype wire

// File: rtl/fifo_stream_drain_skid_buf.sv
//------------------------------------------------------------------------------
// Module   : drain_skid_buf
// Brief    : 2-entry in-order skid buffer absorbing the FIFO read latency.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module drain_skid_buf #(
    parameter int WIDTH = 16
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             i_push,
    input  wire logic [WIDTH-1:0] i_din,
    input  wire logic             i_pop,
    output logic      [1:0]       o_occ,
    output logic      [WIDTH-1:0] o_head
);

    logic [WIDTH-1:0] r_e0;
    logic [WIDTH-1:0] r_e1;
    logic [1:0]       r_occ;
    logic             w_pop;
    logic             w_push;

    // Pop on an empty buffer or push into a full one is ignored defensively.
    assign w_pop  = i_pop & (r_occ != 2'd0);
    assign w_push = i_push & ((r_occ != 2'd2) | w_pop);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_e0  <= '0;
            r_e1  <= '0;
            r_occ <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0) begin
                        r_e0 <= i_din;
                    end else begin
                        r_e1 <= i_din;
                    end
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_e0  <= r_e1;
                    r_occ <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Occupancy unchanged; the new word lands behind the survivor.
                    if (r_occ == 2'd1) begin
                        r_e0 <= i_din;
                    end else begin
                        r_e0 <= r_e1;
                        r_e1 <= i_din;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign o_occ  = r_occ;
    assign o_head = r_e0;

endmodule

`default_nettype wire

// File: rtl/fifo_stream_drain.sv
//------------------------------------------------------------------------------
// Module   : fifo_stream_drain
// Brief    : FIFO read consumer producing a packet-framed valid/ready stream.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module fifo_stream_drain
    import fifo_stream_drain_pkg::*;
#(
    parameter int FIFO_WIDTH = c_FIFO_WIDTH,
    parameter int PKT_LEN    = c_PKT_LEN,
    parameter int CNT_WIDTH  = c_CNT_WIDTH
) (
    input  wire logic        clk,
    input  wire logic        rst,
    fifo_stream_drain_if.master bus
);

    localparam int                  c_BEAT_W    = beat_width(PKT_LEN);
    localparam logic [c_BEAT_W-1:0] c_LAST_BEAT = c_BEAT_W'(PKT_LEN - 1);

    logic                  r_inflight;
    logic [c_BEAT_W-1:0]   r_beat;
    logic [CNT_WIDTH-1:0]  r_pkt_count;

    logic [1:0]            w_occ;
    logic [FIFO_WIDTH-1:0] w_head;
    logic                  w_valid;
    logic                  w_pop;
    logic                  w_last;
    logic [2:0]            w_credit;
    logic                  w_rd_en;

    assign w_valid  = (w_occ != 2'd0);
    assign w_pop    = w_valid & bus.m_ready;
    assign w_last   = w_valid & (r_beat == c_LAST_BEAT);

    // Slots committed after this cycle; a pop frees one in time for the next capture.
    assign w_credit = {1'b0, w_occ} + {2'b00, r_inflight} - {2'b00, w_pop};
    assign w_rd_en  = ~rst & bus.drain_en & ~bus.fifo_empty & (w_credit < 3'd2);

    drain_skid_buf #(
        .WIDTH (FIFO_WIDTH)
    ) u_skid (
        .clk    (clk),
        .rst    (rst),
        .i_push (r_inflight),
        .i_din  (bus.fifo_dout),
        .i_pop  (w_pop),
        .o_occ  (w_occ),
        .o_head (w_head)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight  <= 1'b0;
            r_beat      <= '0;
            r_pkt_count <= '0;
        end else begin
            r_inflight <= w_rd_en & ~bus.fifo_empty;
            if (w_pop) begin
                r_beat <= w_last ? '0 : r_beat + 1'b1;
                if (w_last) begin
                    r_pkt_count <= r_pkt_count + 1'b1;
                end
            end
        end
    end

    assign bus.fifo_rd_en = w_rd_en;
    assign bus.m_data     = w_head;
    assign bus.m_valid    = w_valid;
    assign bus.m_last     = w_last;
    assign bus.pkt_count  = r_pkt_count;
    assign bus.busy       = r_inflight | w_valid;

endmodule

`default_nettype wire
